// File: rtl/ttl_counter_mod.sv
// ttl_counter_mod: N-bit synchronous up/down modulo counter with load and cascadable RCO.
// Optional snapshot register enabled by TTL_COUNTER_SNAPSHOT_EN.
module ttl_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  input  logic             SNAP,
  output logic [WIDTH-1:0] SQ
);
  localparam logic [WIDTH-1:0] TC = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] q_next;
  logic             out_of_range;
  // Loaded values beyond the modulus wrap to 0 on the next up count.
  assign out_of_range = 32'(Q) >= 32'(MODULUS);
  always_comb
    q_next = !LOAD_N         ? D :
             !(ENP && ENT)   ? Q :
             UP              ? ((Q == TC || out_of_range) ? '0 : Q + WIDTH'(1)) :
             (Q == '0)       ? TC : Q - WIDTH'(1);
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) Q <= RV;
    else     Q <= q_next;
  assign RCO = ENT & (UP ? (Q == TC) : (Q == '0));
`ifdef TTL_COUNTER_SNAPSHOT_EN
  always_ff @(posedge CLK or posedge CLR)
    if (CLR)       SQ <= '0;
    else if (SNAP) SQ <= Q;
`else
  logic unused_snap;
  assign unused_snap = SNAP;
  assign SQ = '0;
`endif
endmodule

// File: tb/tb_ttl_counter_mod.sv
// tb_ttl_counter_mod: scoreboard bench for a mod-10 counter and an 8-bit two-stage cascade.
module tb_ttl_counter_mod;
  localparam int W  = 4;
  localparam int M  = 10;
  localparam int RV = 0;
`ifdef TTL_COUNTER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif
  logic CLK = 0, CLR = 0, LOAD_N = 1, ENP = 0, ENT = 0, UP = 1, SNAP = 0;
  logic [W-1:0] D = '0, Q, SQ;
  logic RCO;
  logic c_load_n = 1, c_enp = 0, c_ent = 0, c_up = 1, c_rco_lo, c_rco;
  logic [7:0] c_d = '0;
  logic [3:0] c_qlo, c_qhi, c_sqlo, c_sqhi;
  typedef struct {int q; int rco; int sq; int c; int crco;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, pushes = 0, pops = 0;
  int m_q = 0, m_sq = 0, m_c = 0;

  always #5 CLK = ~CLK;

  ttl_counter_mod #(.WIDTH(W), .MODULUS(M), .RESET_VAL(RV)) u_dut (
    .CLK(CLK), .CLR(CLR), .LOAD_N(LOAD_N), .ENP(ENP), .ENT(ENT), .UP(UP),
    .D(D), .Q(Q), .RCO(RCO), .SNAP(SNAP), .SQ(SQ));
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_lo (
    .CLK(CLK), .CLR(CLR), .LOAD_N(c_load_n), .ENP(c_enp), .ENT(c_ent), .UP(c_up),
    .D(c_d[3:0]), .Q(c_qlo), .RCO(c_rco_lo), .SNAP(1'b0), .SQ(c_sqlo));
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_hi (
    .CLK(CLK), .CLR(CLR), .LOAD_N(c_load_n), .ENP(c_enp), .ENT(c_rco_lo), .UP(c_up),
    .D(c_d[7:4]), .Q(c_qhi), .RCO(c_rco), .SNAP(1'b0), .SQ(c_sqhi));

  function automatic int step(input int q, input int mod, input bit up);
    return up ? ((q >= mod - 1) ? 0 : q + 1) : ((q == 0) ? mod - 1 : q - 1);
  endfunction

  function automatic int rco_of(input int q, input int mod, input bit ent, input bit up);
    return (ent && (up ? q == mod - 1 : q == 0)) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model the edge about to happen from the inputs as they stand just before it.
  task automatic cycle(input int pre = 4);
    exp_t e;
    #pre;
    if (CLR) begin
      m_q = RV; m_sq = 0; m_c = 0;
    end else begin
      if (SNAP_EN && SNAP) m_sq = m_q;
      if (!LOAD_N) m_q = int'(D);
      else if (ENP && ENT) m_q = step(m_q, M, UP);
      if (!c_load_n) m_c = int'(c_d);
      else if (c_enp && c_ent) m_c = step(m_c, 256, c_up);
    end
    e.q = m_q; e.rco = rco_of(m_q, M, ENT, UP); e.sq = m_sq;
    e.c = m_c; e.crco = rco_of(m_c, 256, c_ent, c_up);
    sb.push_back(e);
    pushes++;
    @(negedge CLK);
  endtask

  task automatic set(input bit ld_n, input int d, input bit enp, input bit ent, input bit up, input bit snap);
    LOAD_N = ld_n; D = W'(d); ENP = enp; ENT = ent; UP = up; SNAP = snap;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        pops++;
        chk("q", int'(Q), e.q);
        chk("rco", int'(RCO), e.rco);
        chk("sq", int'(SQ), e.sq);
        chk("cascade_q", int'({c_qhi, c_qlo}), e.c);
        chk("cascade_rco", int'(c_rco), e.crco);
      end
    end
  end

  initial begin : stimulus
    #1 CLR = 1;
    #2;
    chk("reset_q", int'(Q), RV);
    chk("reset_sq", int'(SQ), 0);
    chk("reset_rco", int'(RCO), 0);
    chk("reset_cascade", int'({c_qhi, c_qlo}), 0);
    @(negedge CLK);
    CLR = 0;
    // Up count through a full modulus-10 cycle; cascade loads 0x0E then counts.
    set(1, 0, 1, 1, 1, 0);
    c_load_n = 0; c_d = 8'h0E; c_enp = 1; c_ent = 1; c_up = 1;
    cycle();
    c_load_n = 1;
    repeat (9) cycle();
    // Down wrap from 0, then hold with ENT low at 0.
    set(1, 0, 1, 1, 0, 0);
    repeat (2) cycle();
    set(0, 0, 1, 1, 0, 0); cycle();
    set(1, 0, 1, 0, 0, 0); repeat (2) cycle();
    // Out-of-range load in both directions.
    set(0, 12, 1, 1, 1, 0); cycle();
    set(1, 0, 1, 1, 1, 0); cycle();
    set(0, 12, 1, 1, 1, 0); cycle();
    set(1, 0, 1, 1, 0, 0); cycle();
    // Snapshot on the 5 -> 6 edge, then hold for three edges.
    set(0, 5, 1, 1, 1, 0); cycle();
    set(1, 0, 1, 1, 1, 1); cycle();
    set(1, 0, 1, 1, 1, 0); repeat (3) cycle();
    // Asynchronous clear at Q=7 between edges, release 1 ns before an edge.
    set(0, 7, 1, 1, 1, 0); cycle();
    set(1, 0, 1, 1, 1, 0);
    #2 CLR = 1;
    #1;
    chk("clr_async_q", int'(Q), RV);
    chk("clr_async_sq", int'(SQ), 0);
    chk("clr_async_cascade", int'({c_qhi, c_qlo}), 0);
    m_q = RV; m_sq = 0; m_c = 0;
    cycle(1);
    #4 CLR = 0;
    cycle(0);
    // Randomised traffic, including out-of-range loads.
    for (int i = 0; i < 400; i++) begin
      set($urandom_range(7) != 0, $urandom_range(15), $urandom_range(3) != 0,
          $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(3) == 0);
      c_load_n = $urandom_range(15) != 0;
      c_d = 8'($urandom_range(255));
      c_enp = $urandom_range(3) != 0;
      c_ent = $urandom_range(3) != 0;
      c_up = $urandom_range(1) == 1;
      cycle();
    end
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge CLK);
    #2;
    chk("drain", pops, pushes);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
